// File: rtl/pulse_delay_timer_pkg.sv
// Shared types and default sizing for the multi-channel pulse delay timer.
package pulse_delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/pdt_channel.sv
// One timer channel: IDLE -> DELAY (D+1 edges) -> PULSE (max(W,1) edges),
// optionally looping back to DELAY in periodic mode.
module pdt_channel
    import pulse_delay_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    output logic             pulse,
    output logic             busy,
    output logic             ovr
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] d_q, d_n;
    logic [CNT_W-1:0] w_q, w_n;
    logic             mode_q, mode_n;
    logic             ovr_q, ovr_n;
    logic             pulse_q, busy_q;
    logic [CNT_W-1:0] w_last;

    // W=0 behaves like W=1, so the pulse counter never underflows.
    assign w_last = (w_q == '0) ? '0 : w_q - CNT_W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d_q;
        w_n     = w_q;
        mode_n  = mode_q;
        ovr_n   = ovr_q;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (start) begin
            state_n = DELAY;
            cnt_n   = delay;
            d_n     = delay;
            w_n     = width;
            mode_n  = mode;
            if (state != IDLE) ovr_n = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                end
                DELAY: begin
                    if (cnt == '0) begin
                        state_n = PULSE;
                        cnt_n   = w_last;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        if (mode_q) begin
                            state_n = DELAY;
                            cnt_n   = d_q;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            d_q     <= '0;
            w_q     <= '0;
            mode_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            d_q     <= d_n;
            w_q     <= w_n;
            mode_q  <= mode_n;
            ovr_q   <= ovr_n;
            pulse_q <= (state_n == PULSE);
            busy_q  <= (state_n != IDLE);
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign ovr   = ovr_q;

endmodule

// File: rtl/pulse_delay_timer.sv
// Array of independent delayed-pulse timer channels with packed
// per-channel delay/width fields.
module pulse_delay_timer
    import pulse_delay_timer_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*CNT_W-1:0] delay,
    input  logic [NCH*CNT_W-1:0] width,
    output logic [NCH-1:0]       pulse,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       ovr
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pdt_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .start(start[i]),
            .abort(abort[i]),
            .mode (mode[i]),
            .delay(delay[i*CNT_W +: CNT_W]),
            .width(width[i*CNT_W +: CNT_W]),
            .pulse(pulse[i]),
            .busy (busy[i]),
            .ovr  (ovr[i])
        );
    end

endmodule
